reg_seq_ctrl: RTL and testbench
===============================

# reg_seq_ctrl

Sequencer and arbiter for the shared W-bit register datapath. It accepts write-readback-clear transactions from N requesters and grants them in round-robin order. Each granted transaction writes the requester's word, waits one clock, reads the register back, reports the readback with a mismatch flag, then clears the register. It sits between the requesters and the register's D/load/clear pins; the register itself stays a separate instance.

## Interface
Parameters:
- W, 32, data width of the controlled register.
- N, 2, number of requesters (N >= 2).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- req  in  N  per-requester request level; held until the matching gnt bit pulses.
- wdata  in  N*W  flattened write words; requester i uses bits [i*W +: W], stable while req[i] is high.
- gnt  out  N  one-hot, one-cycle pulse: the transaction of that requester is accepted.
- busy  out  1  high in every non-IDLE state.
- done  out  1  one-cycle pulse: rdata, done_id and mismatch are valid.
- done_id  out  $clog2(N)  index of the requester whose transaction completed.
- rdata  out  W  word read back from the register.
- mismatch  out  1  rdata != word written; valid only while done is high.
- reg_d  out  W  register D input.
- reg_we  out  1  register load enable.
- reg_clr  out  1  register synchronous clear.
- reg_q  in  W  register Q output.

## Operation
- FSM states: IDLE, WRITE, WAIT, READ, CLEAR.
- IDLE:
  - If any req is high, the arbiter picks a winner.
  - The winner's index and wdata word are latched at the edge.
  - Next state is WRITE.
  - Otherwise stay in IDLE.
- WRITE:
  - gnt[winner]=1, reg_we=1, reg_d=latched word.
  - The register loads at the end of this cycle.
- WAIT: reg_we=0 and reg_clr=0 for exactly one cycle.
- READ: at the end of the cycle, rdata<=reg_q, done_id<=winner, mismatch<=(reg_q != latched word), done<=1.
- CLEAR: reg_clr=1, done=1; next state is IDLE.
- Round-robin arbitration:
  - The search starts at (last winner + 1) mod N.
  - After reset, requester 0 has highest priority.
  - The pointer advances only when a grant is issued.
- reg_d holds the latched word in every state. In IDLE it is 0.
- The latched word and winner are not updated outside IDLE. req and wdata changes after acceptance have no effect.
- A req[i] left high after its gnt pulse is treated as a new request at the next IDLE.

## Timing
- Reset values: state IDLE, gnt=0, busy=0, done=0, done_id=0, rdata=0, mismatch=0, reg_d=0, reg_we=0, pointer=0.
- reg_clr=1 every cycle rst is high, so the register is zeroed by reset.
- Reset mid-transaction:
  - The FSM goes to IDLE at the next edge. No done is issued for the aborted transaction.
  - The register is cleared and the pointer returns to 0.
- Latency, with cycle 0 = IDLE cycle with req sampled high:
  - gnt in cycle 1 (WRITE).
  - Register holds the data from cycle 2.
  - done in cycle 4 (CLEAR).
  - Register is zero from cycle 5 (IDLE).
- Throughput: one transaction per 5 cycles under continuous requests. There is no CLEAR->WRITE bypass.
- Simultaneous requests: exactly one gnt per transaction. The losers stay pending and are served in subsequent transactions in rotation order.
- The outputs gnt, done, rdata, done_id, mismatch, reg_we, reg_clr and busy are all registered or decoded only from the registered state. No combinational path exists from req to gnt.
- Boundary data values 0 and all-ones are transferred unchanged.

## Structure
- Shared package reg_seq_pkg holds:
  - The state enum (IDLE, WRITE, WAIT, READ, CLEAR).
  - Default constants for W and N.
- Sub-module rr_arbiter (parameter N):
  - Inputs: req, pointer.
  - Outputs: one-hot grant and its binary index.
  - Purely combinational; the pointer register lives in reg_seq_ctrl.
- The bench instantiates reg_seq_ctrl plus the existing W-bit register, extended with the clear pin, and a behavioural model of the expected readback.

## Test plan
- Single requester 0, wdata=32'hFFFF_FFFC:
  - gnt=01 in cycle 1, done in cycle 4.
  - rdata=FFFF_FFFC, done_id=0, mismatch=0.
  - reg_q=0 from cycle 5.
- Four back-to-back writes from requester 1 (0000_0000, FFFF_FFFC, FFFF_1FFC, FF8F_1FFC):
  - gnt spaced exactly 5 cycles apart.
  - Each done reports the matching word with mismatch=0.
  - The register is zero in each IDLE cycle.
- Both req high continuously (A5A5_A5A5 on 0, 5A5A_5A5A on 1):
  - Grant order 0,1,0,1.
  - done_id alternates.
  - Only one gnt bit is ever high.
- Fault injection, bench forces reg_q bit 0 stuck-at-1, wdata=0000_0000: done with rdata=0000_0001 and mismatch=1.
- rst asserted during WAIT:
  - No done.
  - All outputs return to reset values at the next edge.
  - reg_q=0.
  - A following pair of simultaneous requests grants requester 0 first.

Source files
------------

// File: rtl/reg_seq_pkg.sv
// Shared definitions for the register write-readback-clear sequencer.
package reg_seq_pkg;

    localparam int W_DEF = 32;
    localparam int N_DEF = 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        WAIT  = 3'd2,
        READ  = 3'd3,
        CLEAR = 3'd4
    } state_t;

endpackage

// File: rtl/reg_seq_ctrl_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr_i, wrapping.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic [N-1:0]         req_i,
    input  logic [$clog2(N)-1:0] ptr_i,
    output logic [N-1:0]         gnt_o,
    output logic [$clog2(N)-1:0] idx_o,
    output logic                 valid_o
);

    localparam int IW = $clog2(N);

    // Scan requesters in rotation order starting at the pointer; first hit wins.
    always_comb begin
        int j;
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        j       = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr_i) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (!valid_o && req_i[j]) begin
                valid_o  = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/reg_seq_ctrl.sv
// Sequencer for the shared register: arbitrates requesters round-robin and runs
// write, one idle cycle, readback with compare, then clear for each winner.
module reg_seq_ctrl
    import reg_seq_pkg::*;
#(
    parameter int W = W_DEF,
    parameter int N = N_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic [N*W-1:0]       wdata,
    output logic [N-1:0]         gnt,
    output logic                 busy,
    output logic                 done,
    output logic [$clog2(N)-1:0] done_id,
    output logic [W-1:0]         rdata,
    output logic                 mismatch,
    output logic [W-1:0]         reg_d,
    output logic                 reg_we,
    output logic                 reg_clr,
    input  logic [W-1:0]         reg_q
);

    localparam int IW = $clog2(N);

    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q;
    logic [IW-1:0]   win_q;
    logic [N-1:0]    gvec_q;
    logic [W-1:0]    word_q;
    logic [W-1:0]    rdata_q;
    logic [IW-1:0]   done_id_q;
    logic            mm_q;

    logic [N-1:0]    arb_gnt;
    logic [IW-1:0]   arb_idx;
    logic            arb_valid;
    logic            accept;

    // Pointer for the next search: one past the requester just accepted.
    function automatic logic [IW-1:0] ptr_after(input logic [IW-1:0] idx);
        if (int'(idx) == N - 1) begin
            return '0;
        end
        return idx + IW'(1);
    endfunction

    rr_arbiter #(.N(N)) u_arb (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .gnt_o   (arb_gnt),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    // Requests are only looked at in IDLE; later req/wdata changes are ignored.
    assign accept = (state_q == IDLE) && arb_valid;

    // Control state: FSM, arbitration pointer, winner and readback result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            win_q     <= '0;
            gvec_q    <= '0;
            rdata_q   <= '0;
            done_id_q <= '0;
            mm_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                win_q  <= arb_idx;
                gvec_q <= arb_gnt;
                ptr_q  <= ptr_after(arb_idx);
            end
            if (state_q == READ) begin
                rdata_q   <= reg_q;
                done_id_q <= win_q;
                mm_q      <= (reg_q != word_q);
            end
        end
    end

    // Data capture: the accepted requester's word, held for the whole transaction.
    always_ff @(posedge clk) begin
        if (accept) begin
            word_q <= wdata[int'(arb_idx)*W +: W];
        end
    end

    // Next-state logic: fixed five-cycle walk once a request is accepted.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (arb_valid) state_d = WRITE;
            WRITE:   state_d = WAIT;
            WAIT:    state_d = READ;
            READ:    state_d = CLEAR;
            CLEAR:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode from registered state only; reset also clears the register.
    assign gnt      = (state_q == WRITE) ? gvec_q : '0;
    assign busy     = (state_q != IDLE);
    assign reg_we   = (state_q == WRITE);
    assign reg_clr  = rst || (state_q == CLEAR);
    assign reg_d    = (state_q == IDLE) ? '0 : word_q;
    assign done     = (state_q == CLEAR);
    assign done_id  = done_id_q;
    assign rdata    = rdata_q;
    assign mismatch = mm_q;

endmodule

// File: tb/tb_reg_seq_ctrl.sv
// Bench for reg_seq_ctrl with a behavioural W-bit register (load + clear) and
// an optional stuck-at-1 on readback bit 0.
module tb_reg_seq_ctrl;

    localparam int W = 32;
    localparam int N = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N-1:0]         req;
    logic [N*W-1:0]       wdata;
    logic [N-1:0]         gnt;
    logic                 busy;
    logic                 done;
    logic [$clog2(N)-1:0] done_id;
    logic [W-1:0]         rdata;
    logic                 mismatch;
    logic [W-1:0]         reg_d;
    logic                 reg_we;
    logic                 reg_clr;
    logic [W-1:0]         reg_q;

    logic [W-1:0]         reg_mem;
    logic                 stuck;
    int                   tests = 0;
    int                   fails = 0;
    int                   cyc = 0;

    reg_seq_ctrl #(.W(W), .N(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .wdata    (wdata),
        .gnt      (gnt),
        .busy     (busy),
        .done     (done),
        .done_id  (done_id),
        .rdata    (rdata),
        .mismatch (mismatch),
        .reg_d    (reg_d),
        .reg_we   (reg_we),
        .reg_clr  (reg_clr),
        .reg_q    (reg_q)
    );

    always #5 clk = ~clk;

    // The controlled register, with clear taking priority over load.
    always_ff @(posedge clk) begin
        if (reg_clr) reg_mem <= '0;
        else if (reg_we) reg_mem <= reg_d;
    end
    assign reg_q = reg_mem | {{(W-1){1'b0}}, stuck};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Grant is one-hot or zero in every cycle.
    always @(negedge clk) begin
        if (rst === 1'b0) chk("gnt_onehot", W'($countones(gnt) > 1), '0);
    end

    // One complete transaction starting in the current IDLE cycle (cycle 0).
    task automatic run_txn(input int id, input logic [W-1:0] word,
                           input logic [W-1:0] exp_rd, input logic exp_mm);
        logic [N-1:0] eg;
        eg = '0;
        eg[id] = 1'b1;
        wdata[id*W +: W] = word;
        req[id] = 1'b1;
        chk("c0_busy", W'(busy), '0);
        tick();
        chk("c1_gnt", W'(gnt), W'(eg));
        chk("c1_we", W'(reg_we), 1);
        chk("c1_reg_d", reg_d, word);
        req[id] = 1'b0;
        tick();
        chk("c2_reg_q", reg_q, word | {{(W-1){1'b0}}, stuck});
        chk("c2_gnt", W'(gnt), '0);
        tick();
        chk("c3_done", W'(done), '0);
        tick();
        chk("c4_done", W'(done), 1);
        chk("c4_rdata", rdata, exp_rd);
        chk("c4_done_id", W'(done_id), W'(id));
        chk("c4_mismatch", W'(mismatch), W'(exp_mm));
        chk("c4_clr", W'(reg_clr), 1);
        tick();
        chk("c5_done", W'(done), '0);
        chk("c5_busy", W'(busy), '0);
        chk("c5_reg_q", reg_q, {{(W-1){1'b0}}, stuck});
    endtask

    typedef struct {
        int           id;
        logic [W-1:0] word;
        logic         stk;
        logic [W-1:0] exp_rd;
        logic         exp_mm;
    } vec_t;

    vec_t         vecs[4];
    logic [W-1:0] bw[4];
    int           ord[4];
    logic [W-1:0] cw[2];
    int           gt_prev;

    initial begin
        vecs[0] = '{id: 0, word: 32'hFFFF_FFFC, stk: 1'b0, exp_rd: 32'hFFFF_FFFC, exp_mm: 1'b0};
        vecs[1] = '{id: 0, word: 32'h0000_0000, stk: 1'b1, exp_rd: 32'h0000_0001, exp_mm: 1'b1};
        vecs[2] = '{id: 1, word: 32'hFFFF_FFFF, stk: 1'b0, exp_rd: 32'hFFFF_FFFF, exp_mm: 1'b0};
        vecs[3] = '{id: 0, word: 32'h0000_0000, stk: 1'b0, exp_rd: 32'h0000_0000, exp_mm: 1'b0};
        bw[0] = 32'h0000_0000; bw[1] = 32'hFFFF_FFFC;
        bw[2] = 32'hFFFF_1FFC; bw[3] = 32'hFF8F_1FFC;
        ord[0] = 0; ord[1] = 1; ord[2] = 0; ord[3] = 1;
        cw[0] = 32'hA5A5_A5A5; cw[1] = 32'h5A5A_5A5A;
        gt_prev = 0;

        rst = 1'b1; req = '0; wdata = '0; stuck = 1'b0;
        tick();
        tick();
        chk("rst_gnt", W'(gnt), '0);
        chk("rst_busy", W'(busy), '0);
        chk("rst_done", W'(done), '0);
        chk("rst_rdata", rdata, '0);
        chk("rst_reg_d", reg_d, '0);
        chk("rst_we", W'(reg_we), '0);
        chk("rst_clr", W'(reg_clr), 1);
        chk("rst_reg_q", reg_q, '0);
        rst = 1'b0;
        tick();

        // Table-driven single transactions.
        for (int v = 0; v < 4; v++) begin
            stuck = vecs[v].stk;
            run_txn(vecs[v].id, vecs[v].word, vecs[v].exp_rd, vecs[v].exp_mm);
            stuck = 1'b0;
        end

        // Back-to-back writes from requester 1 with req held high.
        for (int k = 0; k < 4; k++) begin
            chk("b2b_idle_reg_q", reg_q, '0);
            if (k == 0) begin
                wdata[W +: W] = bw[0];
                req[1] = 1'b1;
            end
            tick();
            chk("b2b_gnt", W'(gnt), W'(2'b10));
            if (k > 0) chk("b2b_spacing", W'(cyc - gt_prev), 5);
            gt_prev = cyc;
            if (k < 3) wdata[W +: W] = bw[k+1];
            else req[1] = 1'b0;
            tick();
            tick();
            tick();
            chk("b2b_done", W'(done), 1);
            chk("b2b_rdata", rdata, bw[k]);
            chk("b2b_done_id", W'(done_id), 1);
            chk("b2b_mismatch", W'(mismatch), '0);
            tick();
        end

        // Both requesters continuously: rotation 0,1,0,1.
        wdata[0 +: W] = cw[0];
        wdata[W +: W] = cw[1];
        req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("rr_gnt", W'(gnt), W'(1 << ord[k]));
            if (k == 3) req = '0;
            tick();
            tick();
            tick();
            chk("rr_done", W'(done), 1);
            chk("rr_done_id", W'(done_id), W'(ord[k]));
            chk("rr_rdata", rdata, cw[ord[k]]);
            chk("rr_mismatch", W'(mismatch), '0);
            tick();
        end

        // Reset asserted during WAIT aborts the transaction and rewinds the pointer.
        wdata[0 +: W] = 32'h1234_5678;
        req = 2'b01;
        tick();
        chk("abort_gnt", W'(gnt), W'(2'b01));
        req = '0;
        tick();
        chk("abort_wait_busy", W'(busy), 1);
        rst = 1'b1;
        tick();
        chk("abort_busy", W'(busy), '0);
        chk("abort_gnt0", W'(gnt), '0);
        chk("abort_done", W'(done), '0);
        chk("abort_done_id", W'(done_id), '0);
        chk("abort_rdata", rdata, '0);
        chk("abort_mismatch", W'(mismatch), '0);
        chk("abort_reg_d", reg_d, '0);
        chk("abort_we", W'(reg_we), '0);
        chk("abort_clr", W'(reg_clr), 1);
        chk("abort_reg_q", reg_q, '0);
        rst = 1'b0;
        tick();
        chk("abort_no_done", W'(done), '0);
        wdata[0 +: W] = 32'h0F0F_0F0F;
        wdata[W +: W] = 32'hF0F0_F0F0;
        req = 2'b11;
        tick();
        chk("post_rst_gnt0", W'(gnt), W'(2'b01));
        req[0] = 1'b0;
        tick();
        tick();
        tick();
        chk("post_rst_done0", W'(done), 1);
        chk("post_rst_rdata0", rdata, 32'h0F0F_0F0F);
        tick();
        tick();
        chk("post_rst_gnt1", W'(gnt), W'(2'b10));
        req = '0;
        tick();
        tick();
        tick();
        chk("post_rst_done1", W'(done), 1);
        chk("post_rst_id1", W'(done_id), 1);
        chk("post_rst_rdata1", rdata, 32'hF0F0_F0F0);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
